// File: rtl/fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_buffer_pkg
// Shared constants and types for the instruction prefetch buffer.
//   XLEN             - machine word width
//   NOP_INSTR        - add x0,x0,x0; also used by the core's flush path
//   PC_RESET_DEFAULT - default first fetch address after reset
//   fetch_entry_t    - one buffered instruction with its PC
//   align_pc()       - clears the two low bits of a redirect target
// -----------------------------------------------------------------------------
package fetch_buffer_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0033;
  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; a misaligned target is truncated.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_buffer_if
// Memory-side fetch port plus the instruction handshake towards IF/ID.
//   mem_req / mem_addr  - fetch request and address (buffer -> memory)
//   mem_rdata           - instruction word, one cycle after mem_req
//   out_ready           - IF/ID can accept the head instruction
//   out_valid           - head entry valid
//   out_instr / out_pc  - head instruction (NOP when empty) and its PC
// Modports: master = fetch buffer side, slave = memory / pipeline side.
// -----------------------------------------------------------------------------
interface fetch_buffer_if;
  import fetch_buffer_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/fetch_buffer_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Generic synchronous FIFO with flush and occupancy count.
//   clk, rst   - clock, asynchronous active-low reset
//   push       - write push_data at the tail
//   pop        - advance the head (ignored when empty)
//   flush      - empty the FIFO; overrides push and pop
//   count      - number of valid entries (0..DEPTH)
//   head_data  - entry at the head; meaningless when count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// Storage is not reset; only pointers and count are.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop  & ~flush & (count != '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_ok = push & ~flush & ((count != CW'(DEPTH)) | pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Instruction prefetch buffer between the single-ported unified memory and
// the IF/ID register. Fetches ahead whenever the data side leaves memory
// idle; a redirect flushes everything buffered or in flight and restarts
// fetching at the target.
//   clk, rst     - clock, asynchronous active-low reset
//   redirect     - taken branch/jump this cycle
//   redirect_pc  - redirect target (low two bits ignored)
//   data_busy    - data side owns memory this cycle; no fetch issued
//   bus          - memory fetch port and IF/ID handshake (master side)
// Parameters: DEPTH (power of two, >= 2), PC_RESET (first fetch address).
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            data_busy,
  fetch_buffer_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [CW-1:0]   count;
  logic [CW:0]     slots_used;
  logic            out_valid;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign out_valid = (count != '0);
  assign pop       = out_valid & bus.out_ready;

  // Slots claimed after this cycle's pop: buffered entries plus the one in
  // flight. A new fetch is only issued if its response is sure to find room.
  assign slots_used = {1'b0, count} + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign issue      = rst & ~redirect & ~data_busy & (slots_used < (CW+1)'(DEPTH));

  // ---- stage p0: issue fetch at fetch_pc ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= PC_RESET;
      vld_p1   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= align_pc(redirect_pc);
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= fetch_pc;
  end

  // ---- stage p1: memory returns the word, write it into the FIFO ----
  assign push       = vld_p1 & ~redirect;
  assign push_entry = '{pc: pc_p1, instr: bus.mem_rdata};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head_data (head_entry)
  );

  // ---- stage p2: head of the FIFO towards IF/ID (no bypass from memory) ----
  assign bus.mem_req   = issue;
  assign bus.mem_addr  = fetch_pc;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? head_entry.instr : NOP_INSTR;
  assign bus.out_pc    = out_valid ? head_entry.pc    : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
// Self-checking bench for fetch_buffer. A memory model answers fetches one
// cycle late with a word derived from the address. The reference model keeps
// a queue of issued fetches with the cycle each one becomes visible, and
// predicts mem_req, mem_addr and the output head from occupancy and order.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        data_busy;

  fetch_buffer_if fb_if ();

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .PC_RESET (PC_RST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .data_busy   (data_busy),
    .bus         (fb_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read memory: answer the cycle after a request.
  always @(posedge clk) begin
    fb_if.mem_rdata <= fb_if.mem_req ? mem_fn(fb_if.mem_addr) : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [31:0] pc;
    int          avail;
  } exp_ent_t;

  exp_ent_t    q[$];
  logic [31:0] next_pc;
  int          cyc;
  int          checks;
  int          failures;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input logic r, input logic [31:0] rpc, input logic busy, input logic rdy);
    logic exp_valid;
    logic pop_e;
    logic exp_req;
    int   occ;
    @(negedge clk);
    redirect        = r;
    redirect_pc     = rpc;
    data_busy       = busy;
    fb_if.out_ready = rdy;
    #1;
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    pop_e     = exp_valid && rdy;
    occ       = q.size() - (pop_e ? 1 : 0);
    exp_req   = !r && !busy && (occ < DEPTH);

    check_eq("out_valid", 32'(fb_if.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("out_pc", fb_if.out_pc, q[0].pc);
      check_eq("out_instr", fb_if.out_instr, mem_fn(q[0].pc));
    end else begin
      check_eq("out_pc_empty", fb_if.out_pc, 32'h0);
      check_eq("out_instr_nop", fb_if.out_instr, NOP_INSTR);
    end
    check_eq("mem_req", 32'(fb_if.mem_req), 32'(exp_req));
    if (exp_req) check_eq("mem_addr", fb_if.mem_addr, next_pc);

    if (r) begin
      q.delete();
      next_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop_e) q.delete(0);
      if (exp_req) begin
        q.push_back('{pc: next_pc, avail: cyc + 2});
        next_pc += 32'd4;
      end
    end
    cyc++;
  endtask

  // Assert reset between edges, check the asynchronous effect, then release
  // just after a rising edge so the following cycle is the first active one.
  task automatic apply_reset();
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(fb_if.out_valid), 32'h0);
    check_eq("rst_out_instr", fb_if.out_instr, NOP_INSTR);
    check_eq("rst_out_pc", fb_if.out_pc, 32'h0);
    check_eq("rst_mem_req", 32'(fb_if.mem_req), 32'h0);
    redirect  = 1'b0;
    data_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    next_pc = PC_RST;
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step(($urandom % 10) == 0, $urandom, ($urandom % 3) == 0, ($urandom % 4) != 0);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    next_pc         = PC_RST;
    rst             = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    data_busy       = 1'b0;
    fb_if.out_ready = 1'b1;

    apply_reset();

    // Streaming from reset: one instruction per cycle after two cycles.
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Back-pressure fills the buffer, then it drains in order.
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Data side busy every other cycle.
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, (i % 2) == 0, 1'b1);

    // Redirect with three entries buffered and one in flight.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0040, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect coinciding with a response and a pop, misaligned target.
    step(1'b1, 32'h0000_1233, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // fetch_pc wrap-around at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    random_steps(400);

    // Reset in the middle of a busy stream.
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    random_steps(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch buffer between the single-ported unified memory and the IF/ID pipeline register. It fetches instructions ahead of the core during cycles when the data side is not using memory, so structural-hazard cycles stop inserting NOPs into the pipeline. On a taken branch or jump it discards all fetched and in-flight instructions and restarts fetching at the redirect target.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, at least 2.
- `PC_RESET`, 32'h0000_0000 — first fetch address after reset.

- `clk`  in  1  — clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `redirect`  in  1  — taken branch/jump (`shouldJump`) this cycle.
- `redirect_pc`  in  32  — target PC; sampled when `redirect`=1.
- `data_busy`  in  1  — the data side owns memory this cycle (EX/MEM MemRead | MemWrite).
- `mem_req`  out  1  — fetch request this cycle.
- `mem_addr`  out  32  — fetch address; valid while `mem_req`=1.
- `mem_rdata`  in  32  — instruction word; valid the cycle after an issued `mem_req` (synchronous read).
- `out_ready`  in  1  — IF/ID can accept (`!stall`).
- `out_valid`  out  1  — head entry is valid.
- `out_instr`  out  32  — head instruction, or the NOP 32'h0000_0033 when empty.
- `out_pc`  out  32  — PC of the head instruction; 0 when empty.

## Operation
- State: `fetch_pc` (32), FIFO of {pc, instr} × DEPTH, `count` (0..DEPTH), `inflight` (1 bit), `inflight_pc` (32).
- Issue: `mem_req` = `rst` & !`redirect` & !`data_busy` & (`count` + `inflight` − pop < DEPTH). Here pop = `out_valid` & `out_ready`. `mem_addr` = `fetch_pc`.
- On issue: `inflight`←1, `inflight_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (mod 2^32, wraps silently).
- Response: when `inflight`=1 and `redirect`=0, push {`inflight_pc`, `mem_rdata`}. Slot accounting guarantees a free entry. `inflight` clears unless a new issue happens in the same cycle.
- Pop: head advances when `out_valid` & `out_ready`. Simultaneous push and pop leave `count` unchanged, including when full.
- Redirect has priority over every other event: `count`←0, pointers←0, `inflight`←0 (the pending `mem_rdata` is discarded), `fetch_pc`←`redirect_pc`. No issue and no push occur in that cycle. A pop in the same cycle is irrelevant because the buffer is flushed.
- `out_valid` = (`count`≠0). `out_instr`/`out_pc` are driven from the head register only; there is no bypass from `mem_rdata`.
- `redirect_pc` bits [1:0] are forced to 0.
- Reset (`rst`=0, asynchronous): `fetch_pc`=PC_RESET, `count`=0, `inflight`=0, pointers=0. Outputs: `out_valid`=0, `out_instr`=NOP, `out_pc`=0, `mem_req`=0.
- Asserting reset mid-fetch drops the in-flight response.

## Timing
- Issue at cycle N → `mem_rdata` at N+1 → entry written at end of N+1 → `out_valid` at N+2. Minimum fetch latency is 2 cycles.
- Redirect at cycle R: first issue at R+1, earliest `out_valid` for the target at R+3.
- With `data_busy`=0 and `out_ready`=1 held, steady state is one instruction per cycle.
- While `data_busy`=1, no issue occurs. Buffered entries continue to drain.
- `out_ready`=0 holds the head and all outputs stable. Issue stops once `count`+`inflight` = DEPTH.
- Release after reset: first issue in the first cycle with `rst`=1 and `data_busy`=0.

## Structure
- Shared package: `NOP_INSTR` = 32'h0000_0033 (add x0,x0,x0), `PC_RESET_DEFAULT`, `XLEN`=32. The core's flush path reuses the same NOP constant.
- One sub-module, `fetch_fifo`: a generic synchronous FIFO (WIDTH, DEPTH) with push, pop, flush, count, head outputs, and the same async active-low reset.
- The top level holds `fetch_pc`, the in-flight tracking, and the issue logic.

## Test plan
- Reset release, `data_busy`=0, `out_ready`=1: `mem_addr` sequence 0,4,8,… from cycle 0. `out_valid` first rises at cycle 2 with `out_pc`=0; one instruction per cycle after that.
- `out_ready`=0 for 10 cycles, DEPTH=4: exactly 4 issues occur, `mem_req` then stays 0, and the head stays at pc 0. On release, pcs 0,4,8,12,16 appear on consecutive cycles.
- `data_busy` pulses high every other cycle: no `mem_req` in busy cycles, and the output pcs remain strictly sequential with no gaps.
- `redirect`=1 with `redirect_pc`=32'h40 while 3 entries are buffered and 1 is in flight: `out_valid`=0 at R+1 and R+2, and `out_pc`=32'h40 at R+3. No stale pc appears afterwards.
- `redirect` in the same cycle as a response and a pop: the response is dropped and the next `mem_addr` is `redirect_pc`.
- `rst` asserted mid-stream for 1 cycle: `out_valid`=0 and `out_instr`=32'h33 immediately (asynchronously). Fetch restarts at PC_RESET.
